// File: rtl/pll_sup_pkg.sv
// ============================================================================
// Module   : pll_sup_pkg
// Purpose  : Shared state type, default parameters and counter sizing helper
//            for the PLL lock supervisor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_sup_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_sup_state_e;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int DEF_CNT_W            = 8;

    // A dwell of N cycles counts 0..N-1, so $clog2(N) bits suffice (min 1).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_sup_sync.sv
// ============================================================================
// Module   : pll_sup_sync
// Purpose  : Two-flop synchronizer bringing the PLL lock flag into clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_sup_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : Pulses the PLL reset, waits for a stable lock, then releases the
//            downstream reset. Lock-loss counter built when PLL_SUP_LOSS_CNT_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             timeout_err
`ifdef PLL_SUP_LOSS_CNT_EN
    ,
    output logic [CNT_W-1:0] loss_cnt
`endif
);

    localparam int c_RST_W = cnt_width(RST_PULSE_CYC);
    localparam int c_ST_W  = cnt_width(LOCK_STABLE_CYC);
    localparam int c_TO_W  = cnt_width(LOCK_TIMEOUT_CYC);

    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_PULSE_CYC - 1);
    localparam logic [c_ST_W-1:0]  c_ST_LAST  = c_ST_W'(LOCK_STABLE_CYC - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(LOCK_TIMEOUT_CYC - 1);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    pll_sup_state_e     r_state;
    pll_sup_state_e     w_next;
    logic               w_timeout;
    logic               w_locked_s;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic [c_ST_W-1:0]  r_st_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_timeout_err;

    pll_sup_sync u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (w_locked_s)
    );

    // Loss of lock outranks stable-count completion in STABLE.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_rst_cnt == c_RST_LAST) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next = ST_STABLE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_next    = ST_PLL_RST;
                    w_timeout = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!w_locked_s)                 w_next = ST_WAIT_LOCK;
                else if (r_st_cnt == c_ST_LAST)  w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!w_locked_s) w_next = ST_WAIT_LOCK;
            end
            default: w_next = ST_PLL_RST;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as r_state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state       <= ST_PLL_RST;
            r_pll_rst     <= 1'b1;
            r_sys_rst     <= 1'b1;
            r_ready       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_pll_rst     <= (w_next == ST_PLL_RST);
            r_sys_rst     <= (w_next != ST_RUN);
            r_ready       <= (w_next == ST_RUN);
            r_timeout_err <= w_timeout;
        end
    end

    // Dwell counters run only in their own state and clear on any transition.
    always_ff @(posedge refclk) begin
        if (rst || (w_next != r_state)) begin
            r_rst_cnt <= '0;
            r_st_cnt  <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == ST_PLL_RST)   r_rst_cnt <= r_rst_cnt + 1'b1;
            if (r_state == ST_STABLE)    r_st_cnt  <= r_st_cnt + 1'b1;
            if (r_state == ST_WAIT_LOCK) r_to_cnt  <= r_to_cnt + 1'b1;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign timeout_err = r_timeout_err;

`ifdef PLL_SUP_LOSS_CNT_EN
    logic             w_loss;
    logic [CNT_W-1:0] r_loss_cnt;

    assign w_loss = (r_state == ST_RUN) && !w_locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != {CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Purpose  : Event scoreboard bench for pll_lock_supervisor (small parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int CW = 2;

    localparam logic [3:0] SIG_PLL  = 4'd1;
    localparam logic [3:0] SIG_TO   = 4'd2;
    localparam logic [3:0] SIG_SYS  = 4'd3;
    localparam logic [3:0] SIG_RDY  = 4'd4;
    localparam logic [3:0] SIG_LOSS = 4'd5;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    logic locked = 1'b0;
    logic pll_rst, sys_rst, ready, timeout_err;
    logic [CW-1:0] loss_obs;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic mon_en = 1'b0;
    logic p_pll, p_to, p_sys, p_rdy;
    logic [CW-1:0] p_loss;
    int exp_loss = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (RP),
        .LOCK_STABLE_CYC  (LS),
        .LOCK_TIMEOUT_CYC (LT),
        .CNT_W            (CW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .timeout_err (timeout_err)
`ifdef PLL_SUP_LOSS_CNT_EN
        ,
        .loss_cnt    (loss_obs)
`endif
    );

`ifndef PLL_SUP_LOSS_CNT_EN
    assign loss_obs = '0;
`endif

    always #10 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Event word: signal id, new value, cycle of the edge that produced it.
    function automatic logic [31:0] evt(input logic [3:0] sig, input logic [3:0] val, input int c);
        logic [31:0] w;
        w = c;
        return {sig, val, w[23:0]};
    endfunction

    task automatic expect_evt(input logic [3:0] sig, input logic [3:0] val, input int c);
        exp_q.push_back(evt(sig, val, c));
    endtask

    task automatic observe(input string tag, input logic [3:0] sig, input logic [3:0] val);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        check(tag, evt(sig, val, cyc), e);
    endtask

    // Advance n clocks; output changes seen at each falling edge go to the scoreboard.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge refclk);
            if (mon_en) begin
                if (pll_rst !== p_pll)     observe("pll_rst_evt", SIG_PLL, {3'b0, pll_rst});
                if (timeout_err !== p_to)  observe("timeout_evt", SIG_TO,  {3'b0, timeout_err});
                if (sys_rst !== p_sys)     observe("sys_rst_evt", SIG_SYS, {3'b0, sys_rst});
                if (ready !== p_rdy)       observe("ready_evt",   SIG_RDY, {3'b0, ready});
                if (loss_obs !== p_loss)   observe("loss_evt",    SIG_LOSS, {2'b0, loss_obs});
            end
            p_pll  = pll_rst;
            p_to   = timeout_err;
            p_sys  = sys_rst;
            p_rdy  = ready;
            p_loss = loss_obs;
        end
    endtask

    // Locked low for 5 clocks while in RUN: WAIT_LOCK on the 3rd edge, RUN 11 edges after restore.
    task automatic loss_episode();
        int f, l;
        f = cyc;
        locked = 1'b0;
        expect_evt(SIG_SYS, 4'd1, f + 3);
        expect_evt(SIG_RDY, 4'd0, f + 3);
`ifdef PLL_SUP_LOSS_CNT_EN
        if (exp_loss < 3) begin
            exp_loss++;
            expect_evt(SIG_LOSS, 4'(exp_loss), f + 3);
        end
`endif
        step(5);
        l = cyc;
        locked = 1'b1;
        expect_evt(SIG_SYS, 4'd0, l + 3 + LS);
        expect_evt(SIG_RDY, 4'd1, l + 3 + LS);
        step(14);
    endtask

    initial begin
        int r, x, l, g, h, f, w, t;

        rst = 1'b1;
        locked = 1'b1;
        step(3);
        check("reset_pll_rst", {31'b0, pll_rst}, 32'd1);
        check("reset_sys_rst", {31'b0, sys_rst}, 32'd1);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_timeout", {31'b0, timeout_err}, 32'd0);
        check("reset_loss", {30'b0, loss_obs}, 32'd0);
        mon_en = 1'b1;

        // Power-up with lock present: 4-cycle PLL pulse, 1 WAIT_LOCK cycle, 8 STABLE cycles.
        r = cyc;
        rst = 1'b0;
        expect_evt(SIG_PLL, 4'd0, r + RP);
        expect_evt(SIG_SYS, 4'd0, r + RP + 1 + LS);
        expect_evt(SIG_RDY, 4'd1, r + RP + 1 + LS);
        step(20);
        check("run_ready", {31'b0, ready}, 32'd1);
        check("run_sys_rst", {31'b0, sys_rst}, 32'd0);

        loss_episode();
        check("loss_after_one", {30'b0, loss_obs}, 32'(exp_loss));

        // Reset while in RUN, with lock dropped for the glitch scenario that follows.
        x = cyc;
        rst = 1'b1;
        locked = 1'b0;
        expect_evt(SIG_PLL, 4'd1, x + 1);
        expect_evt(SIG_SYS, 4'd1, x + 1);
        expect_evt(SIG_RDY, 4'd0, x + 1);
`ifdef PLL_SUP_LOSS_CNT_EN
        if (exp_loss != 0) expect_evt(SIG_LOSS, 4'd0, x + 1);
`endif
        exp_loss = 0;
        step(1);
        check("rstrun_pll_rst", {31'b0, pll_rst}, 32'd1);
        check("rstrun_sys_rst", {31'b0, sys_rst}, 32'd1);
        check("rstrun_ready", {31'b0, ready}, 32'd0);
        check("rstrun_loss", {30'b0, loss_obs}, 32'd0);
        step(1);
        r = cyc;
        rst = 1'b0;
        expect_evt(SIG_PLL, 4'd0, r + RP);
        step(6);

        // Lock arrives, then a 3-cycle glitch part way through STABLE.
        l = cyc;
        locked = 1'b1;
        step(5);
        g = cyc;
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        h = cyc;
        check("glitch_sys_rst", {31'b0, sys_rst}, 32'd1);
        // Full stable count from the restore; a non-restarted count would finish earlier.
        expect_evt(SIG_SYS, 4'd0, h + 3 + LS);
        expect_evt(SIG_RDY, 4'd1, h + 3 + LS);
        step(15);
        check("glitch_loss", {30'b0, loss_obs}, 32'd0);
        check("glitch_ready", {31'b0, ready}, 32'd1);
        if (l + 3 > g) $display("note: glitch issued before STABLE entry");

        for (int k = 0; k < 5; k++) loss_episode();
`ifdef PLL_SUP_LOSS_CNT_EN
        check("loss_saturated", {30'b0, loss_obs}, 32'd3);
`endif

        // Permanent lock loss: 32 WAIT_LOCK cycles then timeout, repeating every 36.
        f = cyc;
        locked = 1'b0;
        expect_evt(SIG_SYS, 4'd1, f + 3);
        expect_evt(SIG_RDY, 4'd0, f + 3);
        w = f + 3;
        for (int p = 0; p < 3; p++) begin
            t = w + p * (LT + RP) + LT;
            expect_evt(SIG_PLL, 4'd1, t);
            expect_evt(SIG_TO, 4'd1, t);
            expect_evt(SIG_TO, 4'd0, t + 1);
            expect_evt(SIG_PLL, 4'd0, t + RP);
        end
        step(3 + 3 * (LT + RP) + 2);
        check("timeout_ready", {31'b0, ready}, 32'd0);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
